// File: rtl/matmul_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : matmul_sequencer_if
// Description : Command and MAC-datapath strobe bundle for matmul_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface matmul_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int DIM_W  = 6
);
    logic              start;
    logic [DIM_W-1:0]  dim_m;
    logic [DIM_W-1:0]  dim_k;
    logic [DIM_W-1:0]  dim_n;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] base_c;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic              acc_load;
    logic              acc_en;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;

    modport master (
        output start, dim_m, dim_k, dim_n, base_a, base_b, base_c,
        input  busy, done, rd_en, a_addr, b_addr, acc_load, acc_en, c_we, c_addr
    );

    modport slave (
        input  start, dim_m, dim_k, dim_n, base_a, base_b, base_c,
        output busy, done, rd_en, a_addr, b_addr, acc_load, acc_en, c_we, c_addr
    );
endinterface
`default_nettype wire

// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : matmul_sequencer
// Description : Sequences C = A x B over a MAC datapath with latency-aligned
//               accumulator strobes and result write strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_sequencer #(
    parameter int ADDR_W  = 10,
    parameter int DIM_W   = 6,
    parameter int MEM_LAT = 2
) (
    input  logic               clock,
    input  logic               reset,
    matmul_sequencer_if.slave  bus
);
    localparam int DRAIN_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_rd_en;
    logic                w_c_we;
    logic                w_done;

    logic [DIM_W-1:0]    r_dim_m, r_dim_k, r_dim_n;
    logic [DIM_W-1:0]    r_i, r_j, r_k;
    logic [DRAIN_W-1:0]  r_drain;
    logic [ADDR_W-1:0]   r_base_b;
    logic [ADDR_W-1:0]   r_a_row, r_a_ptr, r_b_col, r_b_ptr, r_c_ptr;
    logic [MEM_LAT-1:0]  r_tag_vld, r_tag_first;

    logic w_k_last, w_i_last, w_j_last, w_dims_ok, w_drain_last, w_first;

    assign w_k_last     = (r_k == r_dim_k - DIM_W'(1));
    assign w_i_last     = (r_i == r_dim_m - DIM_W'(1));
    assign w_j_last     = (r_j == r_dim_n - DIM_W'(1));
    assign w_dims_ok    = (|bus.dim_m) && (|bus.dim_k) && (|bus.dim_n);
    assign w_drain_last = (r_drain == DRAIN_W'(MEM_LAT - 1));
    assign w_first      = (r_k == '0);

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_c_we       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = w_dims_ok ? S_ISSUE : S_DONE;
            S_ISSUE: begin
                w_rd_en = 1'b1;
                if (w_k_last) w_state_next = S_DRAIN;
            end
            S_DRAIN: if (w_drain_last) w_state_next = S_WRITE;
            S_WRITE: begin
                w_c_we       = 1'b1;
                w_state_next = (w_i_last && w_j_last) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Incremental pointers: A walks +1 along a row, B walks +N down a column.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dim_m  <= '0;  r_dim_k <= '0;  r_dim_n <= '0;
            r_i      <= '0;  r_j     <= '0;  r_k     <= '0;
            r_drain  <= '0;
            r_base_b <= '0;
            r_a_row  <= '0;  r_a_ptr <= '0;
            r_b_col  <= '0;  r_b_ptr <= '0;
            r_c_ptr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_dim_m  <= bus.dim_m;
                    r_dim_k  <= bus.dim_k;
                    r_dim_n  <= bus.dim_n;
                    r_base_b <= bus.base_b;
                    r_i      <= '0;
                    r_j      <= '0;
                    r_k      <= '0;
                    r_a_row  <= bus.base_a;
                    r_a_ptr  <= bus.base_a;
                    r_b_col  <= bus.base_b;
                    r_b_ptr  <= bus.base_b;
                    r_c_ptr  <= bus.base_c;
                end
                S_ISSUE: begin
                    r_drain <= '0;
                    if (!w_k_last) begin
                        r_k     <= r_k + DIM_W'(1);
                        r_a_ptr <= r_a_ptr + ADDR_W'(1);
                        r_b_ptr <= r_b_ptr + ADDR_W'(r_dim_n);
                    end
                end
                S_DRAIN: r_drain <= r_drain + DRAIN_W'(1);
                S_WRITE: begin
                    r_k     <= '0;
                    r_c_ptr <= r_c_ptr + ADDR_W'(1);
                    if (w_j_last) begin
                        r_j     <= '0;
                        r_i     <= r_i + DIM_W'(1);
                        r_a_row <= r_a_row + ADDR_W'(r_dim_k);
                        r_a_ptr <= r_a_row + ADDR_W'(r_dim_k);
                        r_b_col <= r_base_b;
                        r_b_ptr <= r_base_b;
                    end else begin
                        r_j     <= r_j + DIM_W'(1);
                        r_a_ptr <= r_a_row;
                        r_b_col <= r_b_col + ADDR_W'(1);
                        r_b_ptr <= r_b_col + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag pipeline delays each read's {valid, first} to when its product arrives.
    generate
        if (MEM_LAT == 1) begin : g_lat1
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_tag_vld   <= '0;
                    r_tag_first <= '0;
                end else begin
                    r_tag_vld   <= w_rd_en;
                    r_tag_first <= w_first;
                end
            end
        end else begin : g_latn
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_tag_vld   <= '0;
                    r_tag_first <= '0;
                end else begin
                    r_tag_vld   <= {r_tag_vld[MEM_LAT-2:0], w_rd_en};
                    r_tag_first <= {r_tag_first[MEM_LAT-2:0], w_first};
                end
            end
        end
    endgenerate

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = w_done;
    assign bus.rd_en    = w_rd_en;
    assign bus.a_addr   = r_a_ptr;
    assign bus.b_addr   = r_b_ptr;
    assign bus.acc_load = r_tag_vld[MEM_LAT-1] &  r_tag_first[MEM_LAT-1];
    assign bus.acc_en   = r_tag_vld[MEM_LAT-1] & ~r_tag_first[MEM_LAT-1];
    assign bus.c_we     = w_c_we;
    assign bus.c_addr   = r_c_ptr;
endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_sequencer
// Description : Randomized self-checking bench with a behavioural MAC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_sequencer;
    localparam int ADDR_W  = 10;
    localparam int DIM_W   = 6;
    localparam int MEM_LAT = 2;
    localparam int ASPACE  = 1 << ADDR_W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    matmul_sequencer_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

    matmul_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .MEM_LAT(MEM_LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int mem_a [ASPACE];
    int mem_b [ASPACE];

    typedef struct { int cyc; int a; int b; }      rd_t;
    typedef struct { int cyc; bit load; }          acc_t;
    typedef struct { int cyc; int addr; int val; } cw_t;

    rd_t  rd_q [$];
    acc_t acc_q [$];
    cw_t  cw_q [$];
    int   done_q [$];
    int   rd_prod [int];
    int   acc_val = 0;
    int   conflicts = 0;
    int   orphans = 0;
    rd_t  m_rd;
    acc_t m_acc;
    cw_t  m_cw;
    int   m_prod;

    // Behavioural RAMs + multiplier + accumulator driven by the DUT strobes
    always @(negedge clock) begin
        if (bus.c_we) begin
            m_cw.cyc = cyc; m_cw.addr = int'(bus.c_addr); m_cw.val = acc_val;
            cw_q.push_back(m_cw);
        end
        if (bus.acc_load && bus.acc_en) conflicts++;
        if (bus.acc_load || bus.acc_en) begin
            if (rd_prod.exists(cyc - MEM_LAT)) m_prod = rd_prod[cyc - MEM_LAT];
            else begin m_prod = 0; orphans++; end
            acc_val = bus.acc_load ? m_prod : acc_val + m_prod;
            m_acc.cyc = cyc; m_acc.load = bus.acc_load;
            acc_q.push_back(m_acc);
        end
        if (bus.rd_en) begin
            rd_prod[cyc] = mem_a[int'(bus.a_addr)] * mem_b[int'(bus.b_addr)];
            m_rd.cyc = cyc; m_rd.a = int'(bus.a_addr); m_rd.b = int'(bus.b_addr);
            rd_q.push_back(m_rd);
        end
        if (bus.done) done_q.push_back(cyc);
    end

    int j_m, j_k, j_n, j_ba, j_bb, j_bc;
    int b_rd, b_acc, b_cw, b_done, b_conf, b_orph;

    function automatic int ref_val(input int i, input int j);
        int s = 0;
        for (int kk = 0; kk < j_k; kk++)
            s += mem_a[(j_ba + i*j_k + kk) % ASPACE] * mem_b[(j_bb + kk*j_n + j) % ASPACE];
        return s;
    endfunction

    task automatic start_job(input int m, input int k, input int n,
                             input int ba, input int bb, input int bc, output int s);
        @(negedge clock);
        j_m = m; j_k = k; j_n = n; j_ba = ba; j_bb = bb; j_bc = bc;
        b_rd = rd_q.size(); b_acc = acc_q.size(); b_cw = cw_q.size();
        b_done = done_q.size(); b_conf = conflicts; b_orph = orphans;
        bus.dim_m  = DIM_W'(m);  bus.dim_k  = DIM_W'(k);  bus.dim_n  = DIM_W'(n);
        bus.base_a = ADDR_W'(ba); bus.base_b = ADDR_W'(bb); bus.base_c = ADDR_W'(bc);
        bus.start  = 1'b1;
        s = cyc;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_q.size() == b_done && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (done_q.size() == b_done) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic count_acc(output int loads, output int ens);
        loads = 0; ens = 0;
        for (int x = b_acc; x < acc_q.size(); x++)
            if (acc_q[x].load) loads++; else ens++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({bus.busy, bus.done, bus.rd_en, bus.acc_load, bus.acc_en, bus.c_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {bus.busy, bus.done, bus.rd_en, bus.acc_load, bus.acc_en, bus.c_we});
        end
        checks++;
        if ({bus.a_addr, bus.b_addr, bus.c_addr} !== '0) begin
            errors++;
            $display("FAIL reset_addr: got a %0d b %0d c %0d expected 0", bus.a_addr, bus.b_addr, bus.c_addr);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_basic;
        int s, loads, ens;
        start_job(2, 2, 2, 0, 16, 32, s);
        wait_done(100);
        checks++;
        if (rd_q.size() - b_rd != 8) begin
            errors++; $display("FAIL basic_rd_count: got %0d expected 8", rd_q.size() - b_rd);
        end else begin
            checks++;
            if (rd_q[b_rd].a != 0 || rd_q[b_rd].b != 16 || rd_q[b_rd+1].a != 1 || rd_q[b_rd+1].b != 18 ||
                rd_q[b_rd].cyc != s+1 || rd_q[b_rd+1].cyc != s+2) begin
                errors++;
                $display("FAIL basic_first_reads: got a %0d,%0d b %0d,%0d expected a 0,1 b 16,18",
                         rd_q[b_rd].a, rd_q[b_rd+1].a, rd_q[b_rd].b, rd_q[b_rd+1].b);
            end
        end
        checks++;
        if (acc_q.size() == b_acc || acc_q[b_acc].cyc != s+3 || !acc_q[b_acc].load) begin
            errors++; $display("FAIL basic_first_acc_load: expected load at cycle %0d", s+3);
        end
        count_acc(loads, ens);
        checks++;
        if (loads != 4 || ens != 4) begin
            errors++; $display("FAIL basic_acc_counts: got load %0d en %0d expected 4 4", loads, ens);
        end
        checks++;
        if (cw_q.size() - b_cw != 4) begin
            errors++; $display("FAIL basic_cw_count: got %0d expected 4", cw_q.size() - b_cw);
        end else begin
            for (int e = 0; e < 4; e++) begin
                checks++;
                if (cw_q[b_cw+e].addr != 32+e || cw_q[b_cw+e].val != ref_val(e/2, e%2)) begin
                    errors++;
                    $display("FAIL basic_cw[%0d]: got addr %0d val %0d expected addr %0d val %0d",
                             e, cw_q[b_cw+e].addr, cw_q[b_cw+e].val, 32+e, ref_val(e/2, e%2));
                end
            end
        end
        checks++;
        if (done_q.size() == b_done || done_q[b_done] != s+21) begin
            errors++; $display("FAIL basic_done_cycle: expected %0d", s+21);
        end
        checks++;
        if (conflicts != b_conf || orphans != b_orph) begin
            errors++; $display("FAIL basic_acc_sanity: got conflicts %0d orphans %0d expected 0 0",
                               conflicts - b_conf, orphans - b_orph);
        end
    endtask

    task automatic test_k1;
        int s, loads, ens;
        start_job(1, 1, 3, 40, 50, 60, s);
        wait_done(100);
        count_acc(loads, ens);
        checks++;
        if (loads != 3 || ens != 0) begin
            errors++; $display("FAIL k1_acc_counts: got load %0d en %0d expected 3 0", loads, ens);
        end
        checks++;
        if (cw_q.size() - b_cw != 3) begin
            errors++; $display("FAIL k1_cw_count: got %0d expected 3", cw_q.size() - b_cw);
        end else begin
            for (int e = 0; e < 3; e++) begin
                checks++;
                if (cw_q[b_cw+e].addr != 60+e || cw_q[b_cw+e].val != ref_val(0, e)) begin
                    errors++;
                    $display("FAIL k1_cw[%0d]: got addr %0d val %0d expected addr %0d val %0d",
                             e, cw_q[b_cw+e].addr, cw_q[b_cw+e].val, 60+e, ref_val(0, e));
                end
            end
        end
        checks++;
        if (done_q.size() == b_done || done_q[b_done] != s+13) begin
            errors++; $display("FAIL k1_done_cycle: expected %0d", s+13);
        end
    endtask

    task automatic test_zero_dim;
        int s;
        start_job(4, 0, 4, 1, 2, 3, s);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL zero_done: got done %b busy %b expected 1 1", bus.done, bus.busy);
        end
        @(negedge clock);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL zero_after: got done %b busy %b expected 0 0", bus.done, bus.busy);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (rd_q.size() != b_rd || cw_q.size() != b_cw) begin
            errors++; $display("FAIL zero_no_strobes: got rd %0d cw %0d expected 0 0",
                               rd_q.size() - b_rd, cw_q.size() - b_cw);
        end
    endtask

    task automatic test_ignore_start;
        int s;
        start_job(2, 2, 2, 100, 200, 300, s);
        repeat (4) @(negedge clock);
        bus.dim_m = 6'd5; bus.dim_k = 6'd5; bus.dim_n = 6'd5;
        bus.base_a = 10'd7; bus.base_b = 10'd8; bus.base_c = 10'd9;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done(100);
        repeat (10) @(negedge clock);
        checks++;
        if (rd_q.size() - b_rd != 8 || done_q.size() - b_done != 1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL ignore_counts: got rd %0d done %0d busy %b expected 8 1 0",
                               rd_q.size() - b_rd, done_q.size() - b_done, bus.busy);
        end
        checks++;
        if (cw_q.size() - b_cw != 4) begin
            errors++; $display("FAIL ignore_cw_count: got %0d expected 4", cw_q.size() - b_cw);
        end else begin
            for (int e = 0; e < 4; e++) begin
                checks++;
                if (cw_q[b_cw+e].addr != 300+e || cw_q[b_cw+e].val != ref_val(e/2, e%2)) begin
                    errors++;
                    $display("FAIL ignore_cw[%0d]: got addr %0d val %0d expected addr %0d val %0d",
                             e, cw_q[b_cw+e].addr, cw_q[b_cw+e].val, 300+e, ref_val(e/2, e%2));
                end
            end
        end
        checks++;
        if (done_q.size() == b_done || done_q[b_done] != s+21) begin
            errors++; $display("FAIL ignore_done_cycle: expected %0d", s+21);
        end
    endtask

    task automatic test_reset_mid_job;
        int s, loads, ens;
        // M=2 K=3 N=2: element (1,0) reads at s+13..s+15, drains at s+16..s+17
        start_job(2, 3, 2, $urandom_range(0, ASPACE-1), $urandom_range(0, ASPACE-1), 500, s);
        repeat (15) @(negedge clock);
        checks++;
        if (rd_q.size() - b_rd != 9 || bus.busy !== 1'b1 || bus.rd_en !== 1'b0) begin
            errors++; $display("FAIL mid_in_drain: got rd %0d busy %b rd_en %b expected 9 1 0",
                               rd_q.size() - b_rd, bus.busy, bus.rd_en);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({bus.busy, bus.done, bus.rd_en, bus.acc_load, bus.acc_en, bus.c_we} !== 6'b0) begin
            errors++; $display("FAIL mid_reset_strobes: got %b expected 000000",
                               {bus.busy, bus.done, bus.rd_en, bus.acc_load, bus.acc_en, bus.c_we});
        end
        reset = 1'b0;
        @(negedge clock);
        start_job(2, 3, 2, 20, 30, 40, s);
        wait_done(100);
        count_acc(loads, ens);
        checks++;
        if (loads != 4 || ens != 8 || orphans != b_orph || acc_q[b_acc].cyc != s+3) begin
            errors++; $display("FAIL mid_clean_acc: got load %0d en %0d orphans %0d expected 4 8 0",
                               loads, ens, orphans - b_orph);
        end
        checks++;
        if (cw_q.size() - b_cw != 4) begin
            errors++; $display("FAIL mid_cw_count: got %0d expected 4", cw_q.size() - b_cw);
        end else begin
            for (int e = 0; e < 4; e++) begin
                checks++;
                if (cw_q[b_cw+e].addr != 40+e || cw_q[b_cw+e].val != ref_val(e/2, e%2)) begin
                    errors++;
                    $display("FAIL mid_cw[%0d]: got addr %0d val %0d expected addr %0d val %0d",
                             e, cw_q[b_cw+e].addr, cw_q[b_cw+e].val, 40+e, ref_val(e/2, e%2));
                end
            end
        end
        checks++;
        if (done_q.size() == b_done || done_q[b_done] != s+25) begin
            errors++; $display("FAIL mid_done_cycle: expected %0d", s+25);
        end
    endtask

    task automatic test_wrap;
        int s;
        int exp_addr [4] = '{1022, 1023, 0, 1};
        start_job(1, 1, 4, 5, 9, ASPACE-2, s);
        wait_done(100);
        checks++;
        if (cw_q.size() - b_cw != 4) begin
            errors++; $display("FAIL wrap_cw_count: got %0d expected 4", cw_q.size() - b_cw);
        end else begin
            for (int e = 0; e < 4; e++) begin
                checks++;
                if (cw_q[b_cw+e].addr != exp_addr[e] || cw_q[b_cw+e].val != ref_val(0, e)) begin
                    errors++;
                    $display("FAIL wrap_cw[%0d]: got addr %0d val %0d expected addr %0d val %0d",
                             e, cw_q[b_cw+e].addr, cw_q[b_cw+e].val, exp_addr[e], ref_val(0, e));
                end
            end
        end
    endtask

    task automatic test_random;
        int s, m, k, n, ba, bb, bc, el, idx, loads, ens;
        rd_t r;
        for (int t = 0; t < 5; t++) begin
            m = $urandom_range(1, 4); k = $urandom_range(1, 4); n = $urandom_range(1, 4);
            ba = $urandom_range(0, ASPACE-1); bb = $urandom_range(0, ASPACE-1);
            bc = $urandom_range(0, ASPACE-1);
            start_job(m, k, n, ba, bb, bc, s);
            wait_done(300);
            el = k + MEM_LAT + 1;
            checks++;
            if (rd_q.size() - b_rd != m*n*k) begin
                errors++; $display("FAIL rand%0d_rd_count: got %0d expected %0d", t, rd_q.size() - b_rd, m*n*k);
            end else begin
                idx = 0;
                for (int i = 0; i < m; i++)
                    for (int j = 0; j < n; j++)
                        for (int kk = 0; kk < k; kk++) begin
                            r = rd_q[b_rd + idx];
                            checks++;
                            if (r.cyc != s+1+(i*n+j)*el+kk || r.a != (ba+i*k+kk) % ASPACE ||
                                r.b != (bb+kk*n+j) % ASPACE) begin
                                errors++;
                                $display("FAIL rand%0d_rd[%0d]: got cyc %0d a %0d b %0d expected cyc %0d a %0d b %0d",
                                         t, idx, r.cyc, r.a, r.b, s+1+(i*n+j)*el+kk,
                                         (ba+i*k+kk) % ASPACE, (bb+kk*n+j) % ASPACE);
                            end
                            idx++;
                        end
            end
            checks++;
            if (cw_q.size() - b_cw != m*n) begin
                errors++; $display("FAIL rand%0d_cw_count: got %0d expected %0d", t, cw_q.size() - b_cw, m*n);
            end else begin
                for (int e = 0; e < m*n; e++) begin
                    checks++;
                    if (cw_q[b_cw+e].cyc != s+(e+1)*el || cw_q[b_cw+e].addr != (bc+e) % ASPACE ||
                        cw_q[b_cw+e].val != ref_val(e/n, e%n)) begin
                        errors++;
                        $display("FAIL rand%0d_cw[%0d]: got cyc %0d addr %0d val %0d expected cyc %0d addr %0d val %0d",
                                 t, e, cw_q[b_cw+e].cyc, cw_q[b_cw+e].addr, cw_q[b_cw+e].val,
                                 s+(e+1)*el, (bc+e) % ASPACE, ref_val(e/n, e%n));
                    end
                end
            end
            count_acc(loads, ens);
            checks++;
            if (loads != m*n || ens != m*n*(k-1) || conflicts != b_conf || orphans != b_orph) begin
                errors++; $display("FAIL rand%0d_acc: got load %0d en %0d conflicts %0d orphans %0d expected %0d %0d 0 0",
                                   t, loads, ens, conflicts - b_conf, orphans - b_orph, m*n, m*n*(k-1));
            end
            checks++;
            if (done_q.size() == b_done || done_q[b_done] != s + m*n*el + 1) begin
                errors++; $display("FAIL rand%0d_done_cycle: expected %0d", t, s + m*n*el + 1);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.dim_m = '0; bus.dim_k = '0; bus.dim_n = '0;
        bus.base_a = '0; bus.base_b = '0; bus.base_c = '0;
        for (int x = 0; x < ASPACE; x++) begin
            mem_a[x] = int'($urandom_range(0, 255));
            mem_b[x] = int'($urandom_range(0, 255));
        end
        test_reset;
        test_basic;
        test_k1;
        test_zero_dim;
        test_ignore_start;
        test_reset_mid_job;
        test_wrap;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
